// File: rtl/sw_pkg.sv
// Shared encodings, BCD limits and the time payload for the stopwatch datapath.
package sw_pkg;

   localparam logic [1:0] SEL_LIVE = 2'b00;
   localparam logic [1:0] SEL_LAP1 = 2'b01;
   localparam logic [1:0] SEL_LAP2 = 2'b10;

   localparam logic [7:0] CS_MAX  = 8'h99;
   localparam logic [7:0] SEC_MAX = 8'h59;
   localparam logic [7:0] MIN_MAX = 8'h59;

   // Elapsed time as BCD MM:SS.CC
   typedef struct packed {
      logic [7:0] min;
      logic [7:0] sec;
      logic [7:0] cs;
   } sw_time_t;

   localparam sw_time_t TIME_ZERO = '0;
   localparam sw_time_t TIME_MAX  = '{min: MIN_MAX, sec: SEC_MAX, cs: CS_MAX};

   function automatic logic time_at_max(input sw_time_t t);
      return (t == TIME_MAX);
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter 00..MAX_BCD; carry flags the wrapping increment.
module bcd_mod_counter #(
   parameter logic [7:0] MAX_BCD = 8'h99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] q,
   output logic       carry
);

   // Ones digit wraps at 9 into tens; whole pair wraps at MAX_BCD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 8'h00;
      end else if (clr) begin
         q <= 8'h00;
      end else if (inc) begin
         if (q == MAX_BCD) begin
            q <= 8'h00;
         end else if (q[3:0] == 4'd9) begin
            q <= {q[7:4] + 4'd1, 4'd0};
         end else begin
            q[3:0] <= q[3:0] + 4'd1;
         end
      end
   end

   assign carry = inc & (q == MAX_BCD);

endmodule

// File: rtl/stopwatch_time_datapath.sv
// Stopwatch time datapath: prescaler, BCD MM:SS.CC counter, two lap slots and
// a registered display mux. Optional macro SW_SATURATE_EN makes the time hold
// at 59:59.99 instead of wrapping.
module stopwatch_time_datapath
   import sw_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned TICK_HZ     = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       running,
   input  logic [1:0] display_select,
   input  logic       lap_capture,
   input  logic       clear,
   output logic [7:0] disp_min,
   output logic [7:0] disp_sec,
   output logic [7:0] disp_cs,
   output logic       lap1_valid,
   output logic       lap2_valid,
   output logic       overflow
);

   localparam int unsigned TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int unsigned PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q;
   logic          tick;
   logic          clr_act;
   logic          cap_act;
   logic          cs_inc;
   logic          sec_inc;
   logic          min_inc;
   logic          cs_carry;
   logic          sec_carry;
   logic          min_carry;
   logic          ovf_set;
   logic          lap_ptr;
   sw_time_t      time_q;
   sw_time_t      lap1_q;
   sw_time_t      lap2_q;
   sw_time_t      disp_src;

   // Clear is honoured only while stopped; capture only while running
   assign clr_act = clear & ~running;
   assign cap_act = lap_capture & running;

   // Prescaler holds while stopped so the fractional tick survives a pause
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
      end else if (clr_act) begin
         presc_q <= '0;
      end else if (running) begin
         presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      end
   end

   assign tick = running & (presc_q == PRESC_LAST);

`ifdef SW_SATURATE_EN
   assign cs_inc  = tick & ~time_at_max(time_q);
   assign ovf_set = (tick & time_at_max(time_q)) | min_carry;
`else
   assign cs_inc  = tick;
   assign ovf_set = min_carry;
`endif
   assign sec_inc = cs_carry;
   assign min_inc = sec_carry;

   bcd_mod_counter #(.MAX_BCD(CS_MAX)) u_cs (
      .clk(clk), .rst(rst), .clr(clr_act), .inc(cs_inc), .q(time_q.cs), .carry(cs_carry)
   );

   bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
      .clk(clk), .rst(rst), .clr(clr_act), .inc(sec_inc), .q(time_q.sec), .carry(sec_carry)
   );

   bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
      .clk(clk), .rst(rst), .clr(clr_act), .inc(min_inc), .q(time_q.min), .carry(min_carry)
   );

   // Lap slots fill alternately; pre-tick time is captured on a coincident tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap1_q     <= TIME_ZERO;
         lap2_q     <= TIME_ZERO;
         lap1_valid <= 1'b0;
         lap2_valid <= 1'b0;
         lap_ptr    <= 1'b0;
      end else if (clr_act) begin
         lap1_q     <= TIME_ZERO;
         lap2_q     <= TIME_ZERO;
         lap1_valid <= 1'b0;
         lap2_valid <= 1'b0;
         lap_ptr    <= 1'b0;
      end else if (cap_act) begin
         if (!lap_ptr) begin
            lap1_q     <= time_q;
            lap1_valid <= 1'b1;
         end else begin
            lap2_q     <= time_q;
            lap2_valid <= 1'b1;
         end
         lap_ptr <= ~lap_ptr;
      end
   end

   // Sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (clr_act) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end
   end

   // Display source select; an empty lap slot shows zero
   always_comb begin
      disp_src = time_q;
      case (display_select)
         SEL_LAP1: disp_src = lap1_valid ? lap1_q : TIME_ZERO;
         SEL_LAP2: disp_src = lap2_valid ? lap2_q : TIME_ZERO;
         default:  disp_src = time_q;
      endcase
   end

   // Registered display outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_min <= 8'h00;
         disp_sec <= 8'h00;
         disp_cs  <= 8'h00;
      end else begin
         disp_min <= disp_src.min;
         disp_sec <= disp_src.sec;
         disp_cs  <= disp_src.cs;
      end
   end

endmodule

// File: tb/tb_stopwatch_time_datapath.sv
// Directed bench for stopwatch_time_datapath with TICK_DIV = 10.
module tb_stopwatch_time_datapath;

   logic       clk;
   logic       rst;
   logic       running;
   logic [1:0] display_select;
   logic       lap_capture;
   logic       clear;
   logic [7:0] disp_min;
   logic [7:0] disp_sec;
   logic [7:0] disp_cs;
   logic       lap1_valid;
   logic       lap2_valid;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;

   stopwatch_time_datapath #(
      .CLK_FREQ_HZ(1000),
      .TICK_HZ    (100)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .running       (running),
      .display_select(display_select),
      .lap_capture   (lap_capture),
      .clear         (clear),
      .disp_min      (disp_min),
      .disp_sec      (disp_sec),
      .disp_cs       (disp_cs),
      .lap1_valid    (lap1_valid),
      .lap2_valid    (lap2_valid),
      .overflow      (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       run;
      logic [1:0] sel;
      logic       lap;
      logic       clr;
      int         cyc;
      logic       chk;
      logic [7:0] m;
      logic [7:0] s;
      logic [7:0] c;
      logic [2:0] f;   // {lap1_valid, lap2_valid, overflow}
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic run, input logic [1:0] sel,
                               input logic lap, input logic clr, input int cyc, input logic chk,
                               input logic [7:0] m, input logic [7:0] s, input logic [7:0] c,
                               input logic [2:0] f);
      vec_t v;
      v.name = name; v.run = run; v.sel = sel; v.lap = lap; v.clr = clr;
      v.cyc = cyc; v.chk = chk; v.m = m; v.s = s; v.c = c; v.f = f;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] m, input logic [7:0] s,
                        input logic [7:0] c, input logic [2:0] f);
      logic [26:0] got;
      logic [26:0] exp;
      got = {disp_min, disp_sec, disp_cs, lap1_valid, lap2_valid, overflow};
      exp = {m, s, c, f};
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h:%h.%h flags=%b, expected %h:%h.%h flags=%b",
                    name, got[26:19], got[18:11], got[10:3], got[2:0], m, s, c, f);
   endtask

   // Entered and left at a negedge; strobes last one cycle
   task automatic apply(input vec_t v);
      running        = v.run;
      display_select = v.sel;
      lap_capture    = v.lap;
      clear          = v.clr;
      for (int k = 0; k < v.cyc; k++) begin
         @(posedge clk);
         @(negedge clk);
         lap_capture = 1'b0;
         clear       = 1'b0;
      end
      if (v.chk) check(v.name, v.m, v.s, v.c, v.f);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      //               name            run sel   lap clr cyc  chk  min    sec    cs     flags
      vecs.push_back(mk("reset",        0, 2'd0, 0, 0, 2,    1, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("run1000",      1, 2'd0, 0, 0, 1000, 0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("one_second",   0, 2'd0, 0, 0, 1,    1, 8'h00, 8'h01, 8'h00, 3'b000));
      vecs.push_back(mk("clear_idle",   0, 2'd0, 0, 1, 2,    1, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("run125",       1, 2'd0, 0, 0, 125,  0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("stopped",      0, 2'd0, 0, 0, 50,   1, 8'h00, 8'h00, 8'h12, 3'b000));
      vecs.push_back(mk("resume4",      1, 2'd0, 0, 0, 4,    1, 8'h00, 8'h00, 8'h12, 3'b000));
      vecs.push_back(mk("resume5",      1, 2'd0, 0, 0, 1,    0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("tick_at_rem",  0, 2'd0, 0, 0, 1,    1, 8'h00, 8'h00, 8'h13, 3'b000));
      vecs.push_back(mk("run240",       1, 2'd0, 0, 0, 240,  0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("lap37",        1, 2'd0, 1, 0, 1,    0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("run429",       1, 2'd0, 0, 0, 429,  0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("lap80",        1, 2'd0, 1, 0, 1,    0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("sel_lap1",     0, 2'd1, 0, 0, 2,    1, 8'h00, 8'h00, 8'h37, 3'b110));
      vecs.push_back(mk("sel_lap2",     0, 2'd2, 0, 0, 2,    1, 8'h00, 8'h00, 8'h80, 3'b110));
      vecs.push_back(mk("run249",       1, 2'd0, 0, 0, 249,  0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("lap105",       1, 2'd0, 1, 0, 1,    0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("lap1_overwr",  0, 2'd1, 0, 0, 2,    1, 8'h00, 8'h01, 8'h05, 3'b110));
      vecs.push_back(mk("lap2_kept",    0, 2'd2, 0, 0, 2,    1, 8'h00, 8'h00, 8'h80, 3'b110));
      vecs.push_back(mk("live105",      0, 2'd0, 0, 0, 2,    1, 8'h00, 8'h01, 8'h05, 3'b110));
      vecs.push_back(mk("run8",         1, 2'd0, 0, 0, 8,    0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("lap_on_tick",  1, 2'd0, 1, 0, 1,    0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("lap2_pretick", 0, 2'd2, 0, 0, 2,    1, 8'h00, 8'h01, 8'h05, 3'b110));
      vecs.push_back(mk("live106",      0, 2'd0, 0, 0, 2,    1, 8'h00, 8'h01, 8'h06, 3'b110));
      vecs.push_back(mk("sel11_live",   0, 2'd3, 0, 0, 2,    1, 8'h00, 8'h01, 8'h06, 3'b110));
      vecs.push_back(mk("lap_idle_ign", 0, 2'd1, 1, 0, 2,    1, 8'h00, 8'h01, 8'h05, 3'b110));
      vecs.push_back(mk("clr_running",  1, 2'd0, 0, 1, 1,    0, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("clr_ignored",  0, 2'd0, 0, 0, 2,    1, 8'h00, 8'h01, 8'h06, 3'b110));
      vecs.push_back(mk("clr_and_lap",  0, 2'd1, 1, 1, 2,    1, 8'h00, 8'h00, 8'h00, 3'b000));
      vecs.push_back(mk("live_cleared", 0, 2'd0, 0, 0, 2,    1, 8'h00, 8'h00, 8'h00, 3'b000));

      rst            = 1'b1;
      running        = 1'b0;
      display_select = 2'b00;
      lap_capture    = 1'b0;
      clear          = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) apply(vecs[i]);

      // Preload 59:59.98 by forcing the counter increments while stopped
      force dut.cs_inc  = 1'b1;
      force dut.sec_inc = 1'b1;
      force dut.min_inc = 1'b1;
      repeat (59) @(posedge clk);
      @(negedge clk);
      release dut.sec_inc;
      release dut.min_inc;
      repeat (39) @(posedge clk);
      @(negedge clk);
      release dut.cs_inc;
      @(posedge clk);
      @(negedge clk);
      check("preload", 8'h59, 8'h59, 8'h98, 3'b000);

      // Three ticks across the top of the range
      running = 1'b1;
      repeat (30) @(posedge clk);
      @(negedge clk);
      running = 1'b0;
      @(posedge clk);
      @(negedge clk);
`ifdef SW_SATURATE_EN
      check("saturate", 8'h59, 8'h59, 8'h99, 3'b001);
`else
      check("wrap", 8'h00, 8'h00, 8'h01, 3'b001);
`endif

      // Clear while stopped drops overflow
      clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("clear_ovf", 8'h00, 8'h00, 8'h00, 3'b000);

      // Run with one capture, then hit reset off the clock edge
      running     = 1'b1;
      lap_capture = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lap_capture = 1'b0;
      repeat (54) @(posedge clk);
      @(negedge clk);
      check("pre_reset", 8'h00, 8'h00, 8'h05, 3'b100);
      #2 rst = 1'b1;
      #1 check("async_reset", 8'h00, 8'h00, 8'h00, 3'b000);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      running = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_reset", 8'h00, 8'h00, 8'h03, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
